// File: rtl/md5_result_collector.sv
// Collects digests from an array of md5calculator cores and drains
// them round-robin onto one valid/ready stream of {index, digest}.
module md5_result_collector #(
    parameter int CORE_COUNT = 8,
    parameter int IDX_WIDTH  = $clog2(CORE_COUNT),
    parameter int CNT_WIDTH  = $clog2(CORE_COUNT + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CORE_COUNT-1:0]     core_done,
    input  logic [CORE_COUNT*128-1:0] core_md5,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IDX_WIDTH-1:0]      out_index,
    output logic [127:0]              out_md5,
    output logic [CNT_WIDTH-1:0]      result_count,
    output logic                      overrun,
    output logic                      all_done
);

    logic [CORE_COUNT-1:0] done_q;
    logic [CORE_COUNT-1:0] pending_q, pending_d;
    logic [127:0]          cap_q [CORE_COUNT];
    logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;
    logic                  valid_q, valid_d;
    logic [IDX_WIDTH-1:0]  index_q, index_d;
    logic [127:0]          md5_q, md5_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  overrun_q, overrun_d;

    logic [CORE_COUNT-1:0] rise;
    logic [CORE_COUNT-1:0] grant_vec;
    logic [IDX_WIDTH-1:0]  grant;
    logic                  any_pend;
    logic                  slot_free;
    logic                  fire;
    int                    j;

    // Rotating priority search; lowest offset from ptr wins.
    always_comb begin
        grant = '0;
        j     = 0;
        for (int k = CORE_COUNT - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= CORE_COUNT) j = j - CORE_COUNT;
            if (pending_q[j]) grant = IDX_WIDTH'(j);
        end
    end

    always_comb begin
        rise      = core_done & ~done_q;
        any_pend  = |pending_q;
        slot_free = ~valid_q | out_ready;
        fire      = valid_q & out_ready;
        grant_vec = '0;
        ptr_d     = ptr_q;
        valid_d   = valid_q;
        index_d   = index_q;
        md5_d     = md5_q;
        count_d   = count_q;
        if (slot_free) begin
            valid_d = any_pend;
            if (any_pend) begin
                grant_vec = CORE_COUNT'(1) << grant;
                index_d   = grant;
                md5_d     = cap_q[grant];
                if (int'(grant) == CORE_COUNT - 1) ptr_d = '0;
                else                               ptr_d = grant + 1'b1;
            end
        end
        // A fresh rise on the granted core re-arms it rather than overrunning.
        pending_d = (pending_q & ~grant_vec) | rise;
        overrun_d = overrun_q | (|(rise & pending_q & ~grant_vec));
        if (fire && count_q != CNT_WIDTH'(CORE_COUNT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_q    <= '0;
            pending_q <= '0;
            ptr_q     <= '0;
            valid_q   <= 1'b0;
            index_q   <= '0;
            md5_q     <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < CORE_COUNT; i++) cap_q[i] <= '0;
        end else begin
            done_q    <= core_done;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            valid_q   <= valid_d;
            index_q   <= index_d;
            md5_q     <= md5_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < CORE_COUNT; i++) begin
                if (rise[i]) cap_q[i] <= core_md5[i*128 +: 128];
            end
        end
    end

    assign out_valid    = valid_q;
    assign out_index    = index_q;
    assign out_md5      = md5_q;
    assign result_count = count_q;
    assign overrun      = overrun_q;
    assign all_done     = (count_q == CNT_WIDTH'(CORE_COUNT)) & ~valid_q;

endmodule
